// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: machine word width,
// FSM state encoding and the default NOP substituted on misaligned fetches.
package inst_fetch_pkg;

   localparam int unsigned MXLEN  = 64;
   localparam int unsigned INST_W = 32;

   // addi x0, x0, 0
   localparam logic [INST_W-1:0] NOP_DEFAULT = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_ACK = 2'd1,
      DISCARD  = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched instructions.
// Ports: clk, rst (sync, active-low), flush (empties buffer), push/push_data,
//        pop, head (entry at read pointer), count (occupancy 0..DEPTH).
// Push and pop in the same cycle are allowed at any occupancy, including full.
module fetch_fifo #(
   parameter int unsigned WIDTH = 97,
   parameter int unsigned DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Storage carries no reset; validity is tracked by count
   always_ff @(posedge clk) begin
      if (rst && !flush && push) mem[wr_ptr] <= push_data;
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: accepts PCs from the PC generator, issues one
// outstanding instruction-memory read at a time and buffers results for decode.
// Ports: clk, rst (sync, active-low); pc_i/ce_i/stall_req_o (PC generator);
//        flush_i (redirect); mem_req_o/mem_addr_o/mem_ack_i/mem_rdata_i (memory);
//        id_valid_o/id_ready_i/id_pc_o/id_inst_o/id_misalign_o (decode).
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter int unsigned        ADDR_W   = MXLEN,
   parameter int unsigned        DEPTH    = 2,
   parameter logic [INST_W-1:0]  NOP_INST = NOP_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic              ce_i,
   input  logic              flush_i,
   output logic              stall_req_o,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic              mem_ack_i,
   input  logic [INST_W-1:0] mem_rdata_i,
   output logic              id_valid_o,
   input  logic              id_ready_i,
   output logic [ADDR_W-1:0] id_pc_o,
   output logic [INST_W-1:0] id_inst_o,
   output logic              id_misalign_o
);

   localparam int unsigned ENT_W = ADDR_W + INST_W + 1;
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   fetch_state_e      state_q;
   fetch_state_e      state_d;
   logic              mis_pend_q;
   logic [ADDR_W-1:0] mis_pc_q;
   logic [CNT_W-1:0]  count;
   logic [ENT_W-1:0]  push_data;
   logic [ENT_W-1:0]  head;
   logic              accept;
   logic              aligned;
   logic              push;
   logic              pop;
   logic              ack_push;

   assign aligned = (pc_i[1:0] == 2'b00);

   // A misaligned NOP awaiting its push already owns a buffer slot
   assign accept = rst && ce_i && !flush_i && (state_q == IDLE) &&
                   ((count + CNT_W'(mis_pend_q)) < CNT_W'(DEPTH));

   assign stall_req_o = rst && ce_i && !accept;

   assign ack_push  = (state_q == WAIT_ACK) && mem_ack_i;
   assign push      = !flush_i && (ack_push || mis_pend_q);
   assign push_data = mis_pend_q ? ENT_W'({mis_pc_q, NOP_INST, 1'b1})
                                 : ENT_W'({mem_addr_o, mem_rdata_i, 1'b0});
   assign pop       = id_valid_o && id_ready_i && !flush_i;

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (accept && aligned) state_d = WAIT_ACK;
         WAIT_ACK: begin
            if (mem_ack_i)    state_d = IDLE;
            else if (flush_i) state_d = DISCARD;
         end
         DISCARD:  if (mem_ack_i) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // State and registered memory-side outputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         mem_req_o  <= 1'b0;
         mem_addr_o <= '0;
         mis_pend_q <= 1'b0;
         mis_pc_q   <= '0;
      end else begin
         state_q    <= state_d;
         mem_req_o  <= (state_d != IDLE);
         mis_pend_q <= accept && !aligned;
         if (accept) begin
            if (aligned) mem_addr_o <= pc_i;
            else         mis_pc_q   <= pc_i;
         end
      end
   end

   fetch_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush_i),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .count     (count)
   );

   assign id_valid_o = (count != '0);
   assign {id_pc_o, id_inst_o, id_misalign_o} = head;

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter ADDR_W, 64, width of the PC and memory address (matches `MXLEN).
REQ-002 Parameter DEPTH, 2, number of fetched-instruction buffer entries (power of 2, ≥2).
REQ-003 Parameter NOP_INST, 32'h0000_0013, instruction word substituted on a misaligned fetch.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset is synchronous and active-low (asserted when 0).
REQ-006 pc_i  in  ADDR_W  fetch address from the PC generator.
REQ-007 ce_i  in  1  PC generator enable; pc_i is valid only while high.
REQ-008 flush_i  in  1  jump/redirect taken; discard all fetched and in-flight work.
REQ-009 stall_req_o  out  1  high = pc_i not accepted this cycle; the PC generator holds pc_i.
REQ-010 mem_req_o  out  1  instruction memory read request.
REQ-011 mem_addr_o  out  ADDR_W  read address, stable while mem_req_o is high.
REQ-012 mem_ack_i  in  1  memory completion; mem_rdata_i valid this cycle.
REQ-013 mem_rdata_i  in  32  instruction word returned.
REQ-014 id_valid_o  out  1  buffer head valid toward decode.
REQ-015 id_ready_i  in  1  decode consumes the head when id_valid_o & id_ready_i.
REQ-016 id_pc_o  out  ADDR_W  PC of the head entry.
REQ-017 id_inst_o  out  32  instruction of the head entry.
REQ-018 id_misalign_o  out  1  head entry came from a pc_i with pc_i[1:0] != 0.

Function
REQ-019 FSM states IDLE, WAIT_ACK, DISCARD; reset state IDLE.
REQ-020 Accept pc_i when ce_i=1, flush_i=0, state=IDLE and buffer occupancy < DEPTH; stall_req_o = ce_i & !accept.
REQ-021 Aligned accept: latch pc_i into mem_addr_o, go to WAIT_ACK; mem_req_o = 1 exactly while in WAIT_ACK or DISCARD.
REQ-022 Misaligned accept: no memory request; push {pc_i, NOP_INST, misalign=1} next cycle; remain in IDLE.
REQ-023 WAIT_ACK with mem_ack_i=1 and flush_i=0: push {mem_addr_o, mem_rdata_i, 0}, return to IDLE; the next pc_i can be accepted in the following cycle.
REQ-024 Earliest timing: accept in cycle N, mem_req_o high in N+1, ack in N+1 leads to id_valid_o high in N+2 when the buffer was empty.
REQ-025 Buffer is a circular FIFO with ADDR_W-independent pointers that wrap modulo DEPTH; push and pop in the same cycle are legal at any occupancy, including full.
REQ-026 id_* outputs present the FIFO head combinationally from registered storage; id_valid_o = occupancy != 0.
REQ-027 flush_i=1: occupancy becomes 0 next cycle, no push/pop that cycle, pc_i not accepted that cycle.
REQ-028 flush_i in WAIT_ACK without ack: go to DISCARD; mem_req_o and mem_addr_o held until mem_ack_i, then data is dropped and the FSM returns to IDLE.
REQ-029 flush_i in the same cycle as mem_ack_i in WAIT_ACK: drop the data, go to IDLE.
REQ-030 mem_ack_i while in IDLE is ignored.

Reset
REQ-031 While rst=0: state IDLE, occupancy 0, pointers 0, mem_req_o=0, mem_addr_o=0, id_valid_o=0, stall_req_o=0; takes effect at the next edge and overrides everything, including an in-flight request.
REQ-032 After rst is released, the first accept can occur on the first cycle with ce_i=1.

Structure
REQ-033 State encoding and the NOP_INST default belong in the shared defines file alongside `MXLEN/`RESET.
REQ-034 One sub-module, fetch_fifo (DEPTH-entry buffer of {pc, inst, misalign}); the FSM lives in inst_fetch.

Verification
REQ-035 Reset, then ce_i=1, pc_i=0x0, ack one cycle after the request with 0x00500093 -> id_valid_o=1, id_pc_o=0, id_inst_o=0x00500093.
REQ-036 id_ready_i=0, fetch 0x0 and 0x4 -> after 2 entries stall_req_o=1 and mem_req_o=0; raise id_ready_i -> entries popped in order, then fetching resumes.
REQ-037 pc_i=0x6 -> no mem_req_o; entry {0x6, 0x00000013, misalign=1}.
REQ-038 Request to 0x8, flush_i before ack, ack 3 cycles later -> mem_req_o held to the ack, nothing pushed, IDLE afterwards, id_valid_o=0.
REQ-039 flush_i and mem_ack_i in the same cycle, with 1 entry buffered -> buffer empty next cycle, ack data dropped.
REQ-040 rst=0 asserted during WAIT_ACK -> mem_req_o=0 and id_valid_o=0 the next cycle; the late ack is ignored.
